// File: rtl/branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_pkg
// Shared definitions for the execute-stage branch resolver:
//   - decoded opcode layout (control-flow flag bit indices, funct3 position)
//   - default opcode width and default post-redirect bubble count
//   - FSM state encoding
//   - funct3 legality helper for conditional branches
// -----------------------------------------------------------------------------
package branch_resolve_pkg;

  // Decoded opcode layout: [0] BRANCH, [1] JAL, [2] JALR, [5:3] funct3.
  localparam int OPLEN_DEFAULT        = 6;
  localparam int OP_BRANCH_BIT        = 0;
  localparam int OP_JAL_BIT           = 1;
  localparam int OP_JALR_BIT          = 2;
  localparam int OP_FUNCT3_LSB        = 3;

  // Bubbles requested of fetch/decode after a redirect (legal range 1..3).
  localparam int FLUSH_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } br_state_e;

  // funct3 values 010 and 011 have no conditional-branch meaning; the
  // comparator output is undefined for them, so they must resolve not-taken.
  function automatic logic funct3_is_branch(input logic [2:0] funct3);
    return (funct3 != 3'b010) && (funct3 != 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Execute-stage control-flow resolver. Decides whether the current instruction
// redirects fetch, computes the redirect target and the link value, and
// presents a registered result to the memory stage. After a taken redirect
// leaves toward memory, it raises flush_fd for FLUSH_CYCLES cycles and refuses
// new instructions meanwhile.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   valid_de/ready_de upstream handshake (instruction in)
//   decoded_op_de     decoded opcode: BRANCH/JAL/JALR flags + funct3
//   comp_out          comparator result for conditional branches
//   pc_de, imm_de     instruction PC and sign-extended immediate
//   rs1data_de        rs1 operand (JALR base)
//   valid_em/ready_em downstream handshake (result out)
//   jump_en_em        redirect taken
//   jump_addr_em      redirect target
//   link_data_em      pc + 4 (rd writeback for JAL/JALR)
//   misalign_em       taken target not word aligned (trap raised downstream)
//   flush_fd          level request to kill fetch/decode contents
// -----------------------------------------------------------------------------
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int OPLEN        = OPLEN_DEFAULT,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_de,
  output logic             ready_de,
  input  logic [OPLEN-1:0] decoded_op_de,
  input  logic             comp_out,
  input  logic [XLEN-1:0]  pc_de,
  input  logic [XLEN-1:0]  imm_de,
  input  logic [XLEN-1:0]  rs1data_de,
  output logic             valid_em,
  input  logic             ready_em,
  output logic             jump_en_em,
  output logic [XLEN-1:0]  jump_addr_em,
  output logic [XLEN-1:0]  link_data_em,
  output logic             misalign_em,
  output logic             flush_fd
);

  // Counter holds FLUSH_CYCLES-1 at most, so two bits cover the 1..3 range.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  br_state_e       state;
  logic [1:0]      flush_cnt;

  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      funct3;
  logic            taken_de;
  logic [XLEN-1:0] sum_de;
  logic [XLEN-1:0] target_de;
  logic [XLEN-1:0] link_de;
  logic            misalign_de;
  logic            accept;
  logic            load;

  // ---------------------------------------------------------------------------
  // Resolution of the incoming instruction
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a value on every path (defaults
  // first), so no latch is inferred even if a branch is added later.
  always_comb begin
    is_branch   = decoded_op_de[OP_BRANCH_BIT];
    is_jal      = decoded_op_de[OP_JAL_BIT];
    is_jalr     = decoded_op_de[OP_JALR_BIT];
    funct3      = decoded_op_de[OP_FUNCT3_LSB +: 3];

    taken_de    = is_jal | is_jalr | (is_branch & funct3_is_branch(funct3) & comp_out);

    // One shared adder: the base is rs1 for JALR, the PC otherwise.
    sum_de      = (is_jalr ? rs1data_de : pc_de) + imm_de;
    target_de   = sum_de;
    if (is_jalr) begin
      target_de[0] = 1'b0;
    end

    link_de     = pc_de + XLEN'(4);
    misalign_de = taken_de & (target_de[1:0] != 2'b00);
  end

  // Accepting while a taken result departs is allowed by the handshake, but
  // that instruction is on the wrong path and is simply not loaded.
  assign ready_de = (state == ST_IDLE) || ((state == ST_HOLD) && ready_em);
  assign accept   = valid_de && ready_de;
  assign load     = accept && !((state == ST_HOLD) && jump_en_em);

  // ---------------------------------------------------------------------------
  // Control FSM and registered result
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the result datapath, is reset so a
      // reset in any state leaves no stale result visible downstream.
      state        <= ST_IDLE;
      flush_cnt    <= '0;
      valid_em     <= 1'b0;
      jump_en_em   <= 1'b0;
      jump_addr_em <= '0;
      link_data_em <= '0;
      misalign_em  <= 1'b0;
      flush_fd     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_HOLD;
            valid_em <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (ready_em) begin
            if (jump_en_em) begin
              state       <= ST_FLUSH;
              valid_em    <= 1'b0;
              flush_fd    <= 1'b1;
              flush_cnt   <= FLUSH_LOAD;
              jump_en_em  <= 1'b0;
              misalign_em <= 1'b0;
            end else if (!accept) begin
              state    <= ST_IDLE;
              valid_em <= 1'b0;
            end
            // Otherwise a new instruction replaces the departing one and
            // valid_em stays high.
          end
        end

        ST_FLUSH: begin
          if (flush_cnt == 2'd0) begin
            state    <= ST_IDLE;
            flush_fd <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          valid_em <= 1'b0;
          flush_fd <= 1'b0;
        end
      endcase

      if (load) begin
        jump_en_em   <= taken_de;
        jump_addr_em <= target_de;
        link_data_em <= link_de;
        misalign_em  <= misalign_de;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
// Self-checking bench for branch_resolve. A transaction-level model predicts,
// each cycle, whether a result is being presented, whether fetch is being
// flushed and whether the stage is ready; a compare process checks the DUT
// against it on every falling edge. Directed scenarios add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int XLEN  = 32;
  localparam int OPLEN = OPLEN_DEFAULT;
  localparam int FLUSH = FLUSH_CYCLES_DEFAULT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_de;
  logic             ready_de;
  logic [OPLEN-1:0] decoded_op_de;
  logic             comp_out;
  logic [XLEN-1:0]  pc_de;
  logic [XLEN-1:0]  imm_de;
  logic [XLEN-1:0]  rs1data_de;
  logic             valid_em;
  logic             ready_em;
  logic             jump_en_em;
  logic [XLEN-1:0]  jump_addr_em;
  logic [XLEN-1:0]  link_data_em;
  logic             misalign_em;
  logic             flush_fd;

  branch_resolve #(
    .XLEN         (XLEN),
    .OPLEN        (OPLEN),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_de      (valid_de),
    .ready_de      (ready_de),
    .decoded_op_de (decoded_op_de),
    .comp_out      (comp_out),
    .pc_de         (pc_de),
    .imm_de        (imm_de),
    .rs1data_de    (rs1data_de),
    .valid_em      (valid_em),
    .ready_em      (ready_em),
    .jump_en_em    (jump_en_em),
    .jump_addr_em  (jump_addr_em),
    .link_data_em  (link_data_em),
    .misalign_em   (misalign_em),
    .flush_fd      (flush_fd)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          taken;
    logic [31:0] addr;
    logic [31:0] link;
    bit          mis;
  } res_t;

  function automatic res_t predict(input logic [OPLEN-1:0] op, input logic comp,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] rs1);
    res_t r;
    int   f3;
    bit   br, jal, jalr;
    br   = op[OP_BRANCH_BIT];
    jal  = op[OP_JAL_BIT];
    jalr = op[OP_JALR_BIT];
    f3   = int'(op[OP_FUNCT3_LSB +: 3]);
    r.taken = jal || jalr || (br && f3 != 2 && f3 != 3 && comp === 1'b1);
    r.addr  = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    r.link  = pc + 32'd4;
    r.mis   = r.taken && (r.addr % 4 != 0);
    return r;
  endfunction

  bit   m_hold;        // a result is being presented downstream
  int   m_flush_left;  // remaining flush bubbles
  res_t m_res;
  bit   m_rdy, m_acc, m_leave_taken;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold       = 1'b0;
      m_flush_left = 0;
      m_res        = '{taken: 1'b0, addr: '0, link: '0, mis: 1'b0};
    end else begin
      m_rdy         = (m_flush_left == 0) && (!m_hold || ready_em);
      m_acc         = valid_de && m_rdy;
      m_leave_taken = m_hold && ready_em && m_res.taken;
      if (m_flush_left > 0) m_flush_left--;
      else if (m_hold && ready_em) m_hold = 1'b0;
      if (m_leave_taken) m_flush_left = FLUSH;
      if (m_acc && !m_leave_taken) begin
        m_hold = 1'b1;
        m_res  = predict(decoded_op_de, comp_out, pc_de, imm_de, rs1data_de);
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model ready_de", 32'(ready_de), 32'((m_flush_left == 0) && (!m_hold || ready_em)));
      check("model valid_em", 32'(valid_em), 32'(m_hold));
      check("model flush_fd", 32'(flush_fd), 32'(m_flush_left > 0));
      if (m_hold) begin
        check("model jump_en_em",   32'(jump_en_em),  32'(m_res.taken));
        check("model link_data_em", link_data_em,     m_res.link);
        check("model misalign_em",  32'(misalign_em), 32'(m_res.mis));
        if (m_res.taken) check("model jump_addr_em", jump_addr_em, m_res.addr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [OPLEN-1:0] mk_op(input bit br, input bit jal, input bit jalr,
                                             input logic [2:0] f3);
    logic [OPLEN-1:0] op;
    op = '0;
    op[OP_BRANCH_BIT]        = br;
    op[OP_JAL_BIT]           = jal;
    op[OP_JALR_BIT]          = jalr;
    op[OP_FUNCT3_LSB +: 3]   = f3;
    return op;
  endfunction

  task automatic drive(input logic [OPLEN-1:0] op, input logic comp, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1);
    valid_de      = 1'b1;
    decoded_op_de = op;
    comp_out      = comp;
    pc_de         = pc;
    imm_de        = imm;
    rs1data_de    = rs1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    rst_n         = 1'b0;
    valid_de      = 1'b0;
    decoded_op_de = '0;
    comp_out      = 1'b0;
    pc_de         = '0;
    imm_de        = '0;
    rs1data_de    = '0;
    ready_em      = 1'b1;

    // Reset state
    #8;
    check("rst valid_em",     32'(valid_em),    32'd0);
    check("rst jump_en_em",   32'(jump_en_em),  32'd0);
    check("rst jump_addr_em", jump_addr_em,     32'd0);
    check("rst link_data_em", link_data_em,     32'd0);
    check("rst misalign_em",  32'(misalign_em), 32'd0);
    check("rst flush_fd",     32'(flush_fd),    32'd0);
    #4 rst_n = 1'b1;
    #1;
    check("post-rst ready_de", 32'(ready_de), 32'd1);

    // BEQ taken, then two flush cycles
    drive(mk_op(1, 0, 0, 3'b000), 1'b1, 32'h100, 32'h20, 32'h0);
    cyc();
    valid_de = 1'b0;
    check("beq valid_em",   32'(valid_em),   32'd1);
    check("beq jump_en_em", 32'(jump_en_em), 32'd1);
    check("beq jump_addr",  jump_addr_em,    32'h120);
    check("beq no flush",   32'(flush_fd),   32'd0);
    cyc();
    check("beq flush1",     32'(flush_fd),   32'd1);
    check("beq flush1 vld", 32'(valid_em),   32'd0);
    check("beq flush1 rdy", 32'(ready_de),   32'd0);
    cyc();
    check("beq flush2",     32'(flush_fd),   32'd1);
    cyc();
    check("beq flush end",  32'(flush_fd),   32'd0);
    check("beq idle rdy",   32'(ready_de),   32'd1);

    // BNE not taken, back-to-back with a non-control instruction
    drive(mk_op(1, 0, 0, 3'b001), 1'b0, 32'h200, 32'h40, 32'h0);
    cyc();
    check("bne jump_en_em", 32'(jump_en_em), 32'd0);
    check("bne valid_em",   32'(valid_em),   32'd1);
    check("bne ready_de",   32'(ready_de),   32'd1);
    drive(mk_op(0, 0, 0, 3'b000), 1'b0, 32'h204, 32'h8, 32'h0);
    cyc();
    valid_de = 1'b0;
    check("b2b valid_em",   32'(valid_em),   32'd1);
    check("b2b link",       link_data_em,    32'h208);
    check("b2b no flush",   32'(flush_fd),   32'd0);
    cyc();
    check("b2b idle vld",   32'(valid_em),   32'd0);
    check("b2b idle flush", 32'(flush_fd),   32'd0);

    // JALR misaligned target
    drive(mk_op(0, 0, 1, 3'b000), 1'b0, 32'h300, 32'h4, 32'h1003);
    cyc();
    valid_de = 1'b0;
    check("jalr jump_addr", jump_addr_em,     32'h1006);
    check("jalr link",      link_data_em,     32'h304);
    check("jalr misalign",  32'(misalign_em), 32'd1);
    check("jalr jump_en",   32'(jump_en_em),  32'd1);
    cyc();
    cyc();
    cyc();
    check("jalr flush end", 32'(flush_fd),    32'd0);

    // JAL held by back-pressure for three cycles; a waiting instruction is
    // refused, then accepted and dropped as the redirect departs.
    ready_em = 1'b0;
    drive(mk_op(0, 1, 0, 3'b000), 1'b0, 32'h400, 32'h80, 32'h0);
    cyc();
    drive(mk_op(0, 0, 0, 3'b000), 1'b0, 32'h500, 32'h4, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("jal hold addr",  jump_addr_em,   32'h480);
      check("jal hold valid", 32'(valid_em),  32'd1);
      check("jal hold rdy",   32'(ready_de),  32'd0);
      check("jal hold flush", 32'(flush_fd),  32'd0);
      if (i < 2) cyc();
    end
    ready_em = 1'b1;
    #1;
    check("jal release rdy", 32'(ready_de), 32'd1);
    cyc();
    valid_de = 1'b0;
    check("jal flush1",     32'(flush_fd),  32'd1);
    check("jal flush1 vld", 32'(valid_em),  32'd0);
    cyc();
    cyc();
    check("jal flush end",  32'(flush_fd),  32'd0);
    check("jal dropped",    32'(valid_em),  32'd0);

    // Address wrap-around, then reset during the first flush cycle
    drive(mk_op(0, 1, 0, 3'b000), 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    cyc();
    valid_de = 1'b0;
    check("wrap addr",      jump_addr_em,     32'h0000_0010);
    check("wrap link",      link_data_em,     32'hFFFF_FFF4);
    check("wrap misalign",  32'(misalign_em), 32'd0);
    cyc();
    check("wrap flush1",    32'(flush_fd),    32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst valid_em", 32'(valid_em),    32'd0);
    check("midrst jump_en",  32'(jump_en_em),  32'd0);
    check("midrst addr",     jump_addr_em,     32'd0);
    check("midrst link",     link_data_em,     32'd0);
    check("midrst misalign", 32'(misalign_em), 32'd0);
    check("midrst flush",    32'(flush_fd),    32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("midrst rel rdy",  32'(ready_de),    32'd1);
    cyc();
    check("midrst no flush", 32'(flush_fd),    32'd0);
    check("midrst no vld",   32'(valid_em),    32'd0);

    // Unknown funct3 with undefined comparator, then a misaligned BLT
    drive(mk_op(1, 0, 0, 3'b010), 1'bx, 32'h700, 32'h10, 32'h0);
    cyc();
    check("badf3 valid",    32'(valid_em),    32'd1);
    check("badf3 not taken", 32'(jump_en_em), 32'd0);
    check("badf3 misalign", 32'(misalign_em), 32'd0);
    drive(mk_op(1, 0, 0, 3'b100), 1'b1, 32'h600, 32'h6, 32'h0);
    cyc();
    valid_de = 1'b0;
    check("blt taken",      32'(jump_en_em),  32'd1);
    check("blt addr",       jump_addr_em,     32'h606);
    check("blt misalign",   32'(misalign_em), 32'd1);
    cyc();
    check("blt flush1",     32'(flush_fd),    32'd1);
    cyc();
    cyc();
    check("blt flush end",  32'(flush_fd),    32'd0);
    cyc();
    cyc();

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
